// File: rtl/load_pkg.sv
// Shared decode types and constants for the MIPS load unit.
package load_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} load_size_e;

   typedef struct packed {
      logic       valid;
      load_size_e size;
      logic       sign;
   } load_dec_t;

   function automatic load_dec_t decode_load(input logic [5:0] opcode);
      load_dec_t d;
      d.valid = 1'b1;
      d.size  = SZ_WORD;
      d.sign  = 1'b1;
      case (opcode)
         OP_LB:   d.size = SZ_BYTE;
         OP_LH:   d.size = SZ_HALF;
         OP_LW:   d.size = SZ_WORD;
         OP_LBU:  begin d.size = SZ_BYTE; d.sign = 1'b0; end
         OP_LHU:  begin d.size = SZ_HALF; d.sign = 1'b0; end
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic is_misaligned(input load_size_e size, input logic [1:0] off);
      case (size)
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a little-endian read word.
module load_align
   import load_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_off,
   input  load_size_e  i_size,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   // NOTE: o_data gets a value on every path through the block, so no latch is inferred.
   always_comb begin
      case (i_size)
         SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load execution: decode, address, one memory read, writeback to rt.
// Optional macro LOAD_MISALIGN_TRAP_EN turns misaligned LH/LHU/LW into a fault pulse.
module load_unit
   import load_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       instruction,
   input  logic [31:0]       Read_data1,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [31:0]       rf_wdata
);

   logic [1:0]        r_state;
   logic              r_busy;
   logic              r_done;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_rf_we;
   logic [4:0]        r_rf_waddr;
   logic [31:0]       r_rf_wdata;
   load_size_e        r_size;
   logic              r_sign;
   logic [1:0]        r_off;
   logic [4:0]        r_rt;

   load_dec_t   w_dec;
   logic [31:0] w_ea;
   logic        w_accept;
   logic        w_trap;
   logic [31:0] w_aligned;
   logic [4:0]  w_unused_rs;

   assign w_dec       = decode_load(instruction[31:26]);
   assign w_ea        = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
   assign w_accept    = (r_state == S_IDLE) && start && w_dec.valid;
   assign w_unused_rs = instruction[25:21];

`ifdef LOAD_MISALIGN_TRAP_EN
   logic r_fault;

   assign w_trap = is_misaligned(w_dec.size, w_ea[1:0]);
   assign fault  = r_fault;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_fault <= 1'b0;
      else        r_fault <= w_accept && w_trap;
   end
`else
   assign w_trap = 1'b0;
   assign fault  = 1'b0;
`endif

   load_align u_align (
      .i_rdata (mem_rdata),
      .i_off   (r_off),
      .i_size  (r_size),
      .i_sign  (r_sign),
      .o_data  (w_aligned)
   );

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_size     <= SZ_WORD;
         r_sign     <= 1'b0;
         r_off      <= '0;
         r_rt       <= '0;
      end else begin
         r_done  <= 1'b0;
         r_rf_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_trap) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state    <= S_REQ;
                     r_busy     <= 1'b1;
                     r_mem_req  <= 1'b1;
                     r_mem_addr <= {w_ea[ADDR_W-1:2], 2'b00};
                     r_size     <= w_dec.size;
                     r_sign     <= w_dec.sign;
                     r_off      <= w_ea[1:0];
                     r_rt       <= instruction[20:16];
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Read data is only sampled here, never in the acceptance cycle.
               if (mem_rvalid) begin
                  r_rf_wdata <= w_aligned;
                  r_rf_waddr <= r_rt;
                  r_rf_we    <= (r_rt != 5'd0);
                  r_done     <= 1'b1;
                  r_state    <= S_WB;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

endmodule
